// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder sequencer.
// Operands arrive on a valid/ready handshake. They are added LSB-first, one
// bit per clock, through a full-adder slice made of two half-adder cells and
// a carry flip-flop. The result is held on a valid/ready output handshake.

// Single half-adder cell: sum = a ^ b, carry = a & b.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // The counter only has to hold 0..WIDTH-1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  // Full-adder slice: two half adders plus the carry flip-flop.
  logic x_bit;
  logic g_bit;
  logic s_bit;
  logic p_bit;
  logic carry_next;
  logic [WIDTH-1:0] acc_next;

  half_adder_cell u_ha_first (
    .a (a_sh_reg[0]),
    .b (b_sh_reg[0]),
    .s (x_bit),
    .c (g_bit)
  );

  half_adder_cell u_ha_second (
    .a (x_bit),
    .b (carry_reg),
    .s (s_bit),
    .c (p_bit)
  );

  assign carry_next = g_bit | p_bit;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  assign acc_next   = {s_bit, acc_reg[WIDTH-1:1]};

  // Sequencer: accept operands, shift one bit per cycle, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // in_ready is high in IDLE whenever reset is low.
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= carry_next;
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= acc_next;
            cout_reg  <= carry_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH = 8).
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain (WIDTH+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // One full transaction: accept, measure latency, check result, optional stall.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec, input int stall);
    int lat;
    logic busy_ok;
    logic [W-1:0] held_sum;
    logic held_cout;
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < W + 4) begin
      if (!busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, W);
    chk({tag, " busy during run"}, busy_ok, 1);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    held_sum = sum;
    held_cout = cout;
    for (int i = 0; i < stall; i++) step();
    if (stall > 0) begin
      chk({tag, " stall valid"}, out_valid, 1);
      chk({tag, " stall hold"}, {held_cout, held_sum}, {cout, sum});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " released"}, {out_valid, busy, in_ready}, 3'b001);
    $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d", tag, va, vb, vc, held_sum, held_cout, lat);
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb, hs;
    logic rc, hc, never_valid;
    int acc_cyc[$];
    logic [W:0] exp_q[$];
    logic [W:0] got_q[$];
    int cyc;
    logic acc_now, out_now;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset with random inputs for two cycles.
    rst = 1'b1; out_ready = 1'($urandom);
    in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset in_ready", in_ready, 0);
      chk("reset flags", {out_valid, busy}, 2'b00);
      chk("reset result", {cout, sum}, 0);
      $display("reset cycle %0d: in_ready=%0d out_valid=%0d busy=%0d", i, in_ready, out_valid, busy);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin,
             vecs[i].esum, vecs[i].ecout, i % 3);
    end

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      r = ref_add(ra, rb, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, r[W-1:0], r[W], int'($urandom_range(0, 3)));
    end

    // Backpressure: result held, new offer ignored, then release.
    in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < W + 4 && !out_valid; i++) step();
    chk("bp valid", out_valid, 1);
    hs = sum; hc = cout;
    chk("bp sum", {hc, hs}, 9'h047);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp hold valid", out_valid, 1);
      chk("bp hold result", {cout, sum}, {hc, hs});
      chk("bp in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp to idle", {out_valid, busy, in_ready}, 3'b001);
    repeat (W + 2) step();
    chk("bp not captured", {out_valid, busy}, 2'b00);
    $display("backpressure: held sum=%02h cout=%0d over 5 stalled cycles", hs, hc);

    // Reset during the 4th RUN cycle discards the operation.
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("midrun busy", busy, 1);
    rst = 1'b1;
    step();
    chk("midrun reset state", {out_valid, busy, in_ready}, 3'b000);
    chk("midrun sum", {cout, sum}, 0);
    rst = 1'b0;
    #1;
    chk("midrun in_ready", in_ready, 1);
    never_valid = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (out_valid) never_valid = 1'b0;
    end
    chk("midrun no output", never_valid, 1);
    $display("reset mid-run: operation discarded, sum=%02h", sum);

    // Back-to-back with out_ready tied high and in_valid held.
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    cyc = 0;
    while (got_q.size() < 2 && cyc < 60) begin
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      if (out_now) got_q.push_back({cout, sum});
      @(posedge clk);
      cyc++;
      #1;
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(ref_add(a, b, cin));
        if (acc_cyc.size() == 1) begin
          a = 8'h80; b = 8'h80; cin = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b results", got_q.size(), 2);
    chk("b2b accepts", acc_cyc.size(), 2);
    if (got_q.size() == 2 && acc_cyc.size() == 2) begin
      chk("b2b first", got_q[0], exp_q[0]);
      chk("b2b second", got_q[1], exp_q[1]);
      chk("b2b first const", got_q[0], 9'h003);
      chk("b2b second const", got_q[1], 9'h101);
      chk("b2b spacing", acc_cyc[1] - acc_cyc[0], W + 2);
      $display("back-to-back: %03h then %03h, accepts %0d cycles apart",
               got_q[0], got_q[1], acc_cyc[1] - acc_cyc[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial adder sequencer for the half-adder tile design. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per clock, using a full-adder slice built from two half-adder cells and a carry flip-flop, and presents the WIDTH-bit sum and carry-out through a valid/ready output handshake. It sits between the operand source (pins or upstream logic) and the half-adder datapath, and produces what the output mux drives onto the dedicated outputs.

## Interface
- WIDTH, 8, operand and sum width in bits (legal range 2..16).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, sampled only on input handshake.
- b  input  WIDTH  operand B, sampled only on input handshake.
- cin  input  1  carry-in, sampled only on input handshake.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer takes result this cycle.
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
- cout  output  1  registered carry-out of the addition.
- busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load the a and b shift registers, set carry_ff = cin, clear the bit counter, and go to RUN.
  - in_valid while in_ready = 0 is ignored. No operand is captured.
- RUN, each cycle:
  - x = a_sh[0] ^ b_sh[0], g = a_sh[0] & b_sh[0] (first half adder).
  - s = x ^ carry_ff, p = x & carry_ff (second half adder).
  - Shift s into the MSB of the accumulating result shift register.
  - carry_ff <= g | p. Shift a_sh and b_sh right by one. Increment the counter.
  - On the cycle the counter reaches WIDTH-1: copy the accumulated value, including this cycle's bit, into sum; copy the final carry into cout; go to DONE.
- DONE:
  - out_valid = 1. sum and cout are stable.
  - On out_valid && out_ready: go to IDLE.
  - The FSM stays in DONE indefinitely while out_ready = 0.
- sum and cout are updated only on entry to DONE. They keep their last result after the output handshake until the next result is written. They are meaningful only while out_valid = 1.
- Arithmetic: {cout, sum} = a + b + cin exactly, computed to WIDTH+1 bits. There is no signed interpretation.
- in_ready is combinational from state: (state == IDLE) && !rst. out_valid and busy are decoded from the state register.
- Reset, including mid-RUN or in DONE:
  - Next state is IDLE. sum = 0, cout = 0, out_valid = 0, busy = 0. The shift registers, counter and carry_ff are cleared.
  - Any in-flight operation is discarded with no output.
  - in_ready = 0 during the reset cycle and 1 in the first cycle after rst deasserts.

## Timing
- Input handshake at edge E0 means RUN is active from E0 to E_WIDTH. Bits are processed at edges E1..E_WIDTH.
- out_valid first goes high after edge E_WIDTH, which is a latency of WIDTH cycles from the accepting edge.
- If out_ready is already high, the result transfers at E_WIDTH+1 and in_ready is high after it. The next accept can occur at E_WIDTH+2, so minimum accept-to-accept is WIDTH+2 cycles (10 for WIDTH=8).
- A result and a new operand set are never handshaken on the same edge, because in_ready = 0 in DONE.
- Outputs have no combinational path from a, b, cin or out_ready.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> sum=0, cout=0, out_valid=0, busy=0, in_ready=0 during reset; in_ready=1 on the first cycle after release.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0 -> out_valid rises exactly 8 cycles after the accepting edge with sum=8'h7F, cout=0; busy is high from the accept until the output handshake.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and drive in_valid=1 with a=8'h11, b=8'h22 -> out_valid stays 1, sum/cout are unchanged, in_ready=0, and the new operands are not captured. Raise out_ready -> IDLE the next cycle.
- Reset mid-RUN: accept a=8'hAA, b=8'h55, assert rst on the 4th RUN cycle -> out_valid never asserts for that operation, sum=0, and in_ready=1 the cycle after rst drops.
- Back-to-back with out_ready tied to 1 and in_valid held: (8'h01+8'h02+0) then (8'h80+8'h80+1) -> results 8'h03/cout 0, then 8'h01/cout 1; accepting edges are exactly 10 cycles apart.
